// File: rtl/beat_pkg.sv
// Shared definitions for the beat recorder: default widths, the rest code and
// the playback sequencer state type.
package beat_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NOTE_W_DEF = 8;
    localparam int unsigned NOTE_REST  = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StHold,
        StDone
    } player_state_e;

endpackage

// File: rtl/beat_timer.sv
// Loadable down-counter with a zero flag. It stops at zero and stays there until
// it is reloaded.
module beat_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/record_player.sv
// Playback sequencer: reads recorded notes from the note RAM and presents one
// note per beat to the buzzer, either once or as a continuous loop.
module record_player
    import beat_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NOTE_W   = NOTE_W_DEF,
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_en,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   rec_len,
    input  logic [NOTE_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              playing,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    player_state_e    state_q;
    logic [ADDR_W:0]  addr_q;
    logic [ADDR_W:0]  len_q;
    logic [ADDR_W:0]  addr_nxt;
    logic             last_q;
    logic             more_slots;
    logic             tail_start;
    logic             beat_zero;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;

    assign addr_nxt   = addr_q + 1'b1;
    assign more_slots = (addr_nxt < len_q);

    // The final note of a single pass gets two extra cycles so it is held for a
    // whole beat, matching the FETCH+LATCH time every other note is shown for.
    assign tail_start = (state_q == StHold) && beat_zero && !last_q && !more_slots && !loop_en;
    assign timer_load = play_en && ((state_q == StLatch) || tail_start);
    assign timer_val  = (state_q == StLatch) ? CNT_W'(TICK_DIV - 3) : CNT_W'(1);

    beat_timer #(
        .WIDTH(CNT_W)
    ) u_beat_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(timer_val),
        .zero    (beat_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            note_out   <= NOTE_W'(NOTE_REST);
            note_valid <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            if (!play_en) begin
                state_q    <= StIdle;
                addr_q     <= '0;
                last_q     <= 1'b0;
                ram_addr   <= '0;
                note_valid <= 1'b0;
                playing    <= 1'b0;
                done       <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        len_q  <= rec_len;
                        addr_q <= '0;
                        last_q <= 1'b0;
                        if (rec_len == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q  <= StFetch;
                            ram_addr <= '0;
                            ram_rd   <= 1'b1;
                            playing  <= 1'b1;
                        end
                    end
                    StFetch: begin
                        state_q <= StLatch;
                    end
                    StLatch: begin
                        note_out   <= ram_rdata;
                        note_valid <= 1'b1;
                        state_q    <= StHold;
                    end
                    StHold: begin
                        if (beat_zero) begin
                            if (last_q) begin
                                last_q     <= 1'b0;
                                state_q    <= StDone;
                                note_valid <= 1'b0;
                                playing    <= 1'b0;
                                done       <= 1'b1;
                            end else if (more_slots) begin
                                addr_q   <= addr_nxt;
                                ram_addr <= addr_nxt[ADDR_W-1:0];
                                ram_rd   <= 1'b1;
                                state_q  <= StFetch;
                            end else if (loop_en) begin
                                addr_q   <= '0;
                                ram_addr <= '0;
                                ram_rd   <= 1'b1;
                                state_q  <= StFetch;
                            end else begin
                                last_q <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StDone;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
